// File: rtl/enc_pkg.sv
// Shared types and helpers for the multi-hit encoder.
//   state_t  : encoder FSM state (IDLE, EMIT)
//   popcount : number of set bits in a vector of up to 64 bits
package enc_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

   localparam int MAX_WIDTH = 64;

   function automatic logic [6:0] popcount(input logic [MAX_WIDTH-1:0] vec);
      logic [6:0] n;
      n = '0;
      for (int i = 0; i < MAX_WIDTH; i++) begin
         n = n + {6'b0, vec[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/ffs_encoder.sv
// Combinational find-first-set.
//   in_vec : vector to search
//   idx    : index of lowest set bit (highest when MSB_FIRST=1), 0 if none
//   found  : at least one bit of in_vec is set
module ffs_encoder #(
   parameter int WIDTH     = 8,
   parameter int MSB_FIRST = 0,
   localparam int IDX_W    = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] in_vec,
   output logic [IDX_W-1:0] idx,
   output logic             found
);

   // The last match in each loop wins, so each loop scans toward the
   // end that has priority.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      if (MSB_FIRST != 0) begin
         for (int i = 0; i < WIDTH; i++) begin
            if (in_vec[i]) begin
               idx   = IDX_W'(i);
               found = 1'b1;
            end
         end
      end else begin
         for (int i = WIDTH - 1; i >= 0; i--) begin
            if (in_vec[i]) begin
               idx   = IDX_W'(i);
               found = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/multi_hit_encoder.sv
// Accepts a request vector and emits the index of every set bit, one per
// accepted output beat, lowest first (highest first when MSB_FIRST=1).
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : request vector handshake, in_data = vector
//   out_valid/out_ready   : index handshake
//   out_idx               : current index
//   out_last              : current index is the final one of the burst
//   out_count             : popcount of the captured vector, held per burst
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready for a vector; all-zero vectors are dropped
// EMIT  | presenting indices from pending until the last one is taken
module multi_hit_encoder
   import enc_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int MSB_FIRST = 0,
   localparam int IDX_W    = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_idx,
   output logic             out_last,
   output logic [IDX_W:0]   out_count
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] pending_q, pending_d;
   logic [IDX_W:0]   count_q, count_d;

   logic [IDX_W-1:0]     ffs_idx;
   logic                 ffs_found;
   logic                 one_left;
   logic [WIDTH-1:0]     clr_mask;
   logic [MAX_WIDTH-1:0] in_ext;

   ffs_encoder #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_ffs (
      .in_vec (pending_q),
      .idx    (ffs_idx),
      .found  (ffs_found)
   );

   // x & (x-1) clears the lowest set bit; zero result means at most one bit.
   assign one_left = ((pending_q & (pending_q - WIDTH'(1))) == '0);

   always_comb begin
      clr_mask          = '0;
      clr_mask[ffs_idx] = 1'b1;
   end

   always_comb begin
      in_ext                = '0;
      in_ext[WIDTH-1:0]     = in_data;
   end

   assign in_ready  = (state_q == IDLE) && !rst;
   assign out_valid = (state_q == EMIT);
   assign out_idx   = out_valid ? ffs_idx : '0;
   assign out_last  = out_valid && ffs_found && one_left;
   assign out_count = count_q;

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      count_d   = count_q;
      case (state_q)
         IDLE: begin
            if (in_valid && in_ready && (in_data != '0)) begin
               pending_d = in_data;
               count_d   = (IDX_W+1)'(popcount(in_ext));
               state_d   = EMIT;
            end
         end
         EMIT: begin
            if (out_ready) begin
               pending_d = pending_q & ~clr_mask;
               if (out_last) begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         pending_q <= '0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         count_q   <= count_d;
      end
   end

endmodule

// File: tb/tb_multi_hit_encoder.sv
module tb_multi_hit_encoder;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [7:0] in_data;
   logic       out_ready;

   logic       in_ready0, out_valid0, out_last0;
   logic [2:0] out_idx0;
   logic [3:0] out_count0;
   logic       in_ready1, out_valid1, out_last1;
   logic [2:0] out_idx1;
   logic [3:0] out_count1;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   multi_hit_encoder #(.WIDTH(8), .MSB_FIRST(0)) dut_lsb (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready0),
      .in_data   (in_data),
      .out_valid (out_valid0),
      .out_ready (out_ready),
      .out_idx   (out_idx0),
      .out_last  (out_last0),
      .out_count (out_count0)
   );

   multi_hit_encoder #(.WIDTH(8), .MSB_FIRST(1)) dut_msb (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready1),
      .in_data   (in_data),
      .out_valid (out_valid1),
      .out_ready (out_ready),
      .out_idx   (out_idx1),
      .out_last  (out_last1),
      .out_count (out_count1)
   );

   typedef struct {
      logic [7:0]  vec;
      int          cnt;
      logic [31:0] lsb;   // expected indices, first beat in lowest nibble
      logic [31:0] msb;
   } vec_t;

   vec_t tbl[6];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
      $fatal(1);
   end

   initial begin
      int e;
      int cyc;
      logic taken;

      tbl[0] = '{8'b1010_0100, 3, 32'h0000_0752, 32'h0000_0257};
      tbl[1] = '{8'b0001_0011, 3, 32'h0000_0410, 32'h0000_0014};
      tbl[2] = '{8'hFF,        8, 32'h7654_3210, 32'h0123_4567};
      tbl[3] = '{8'h80,        1, 32'h0000_0007, 32'h0000_0007};
      tbl[4] = '{8'h01,        1, 32'h0000_0000, 32'h0000_0000};
      tbl[5] = '{8'h5A,        4, 32'h0000_6431, 32'h0000_1346};

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      tick();
      tick();
      chk("reset in_ready",  32'(in_ready0),  0);
      chk("reset out_valid", 32'(out_valid0), 0);
      chk("reset out_idx",   32'(out_idx0),   0);
      chk("reset out_last",  32'(out_last0),  0);
      chk("reset out_count", 32'(out_count0), 0);
      rst = 1'b0;
      #1;
      chk("post-reset in_ready", 32'(in_ready0), 1);

      // table-driven bursts with out_ready held high
      for (int t = 0; t < 6; t++) begin
         in_valid = 1'b1;
         in_data  = tbl[t].vec;
         chk("tbl in_ready before", 32'(in_ready0), 1);
         tick();
         in_valid = 1'b0;
         in_data  = '0;
         for (int k = 0; k < tbl[t].cnt; k++) begin
            chk("tbl out_valid",     32'(out_valid0), 1);
            chk("tbl out_valid msb", 32'(out_valid1), 1);
            chk("tbl out_idx",       32'(out_idx0), 32'(tbl[t].lsb[4*k +: 4]));
            chk("tbl out_idx msb",   32'(out_idx1), 32'(tbl[t].msb[4*k +: 4]));
            chk("tbl out_last",      32'(out_last0), (k == tbl[t].cnt - 1) ? 1 : 0);
            chk("tbl out_last msb",  32'(out_last1), (k == tbl[t].cnt - 1) ? 1 : 0);
            chk("tbl out_count",     32'(out_count0), 32'(tbl[t].cnt));
            chk("tbl in_ready busy", 32'(in_ready0), 0);
            tick();
         end
         chk("tbl out_valid after", 32'(out_valid0), 0);
         chk("tbl in_ready after",  32'(in_ready0),  1);
      end

      // full vector with out_ready toggling 1,0,1,0
      in_valid = 1'b1;
      in_data  = 8'hFF;
      tick();
      in_valid = 1'b0;
      in_data  = '0;
      e   = 0;
      cyc = 0;
      out_ready = 1'b1;
      while (e < 8 && cyc < 40) begin
         chk("stall out_valid", 32'(out_valid0), 1);
         chk("stall out_idx",   32'(out_idx0),   32'(e));
         chk("stall out_last",  32'(out_last0),  (e == 7) ? 1 : 0);
         chk("stall out_count", 32'(out_count0), 8);
         chk("stall in_ready",  32'(in_ready0),  0);
         taken = out_ready;
         tick();
         if (taken) e++;
         out_ready = ~out_ready;
         cyc++;
      end
      chk("stall beats", 32'(e), 8);
      out_ready = 1'b1;
      chk("stall out_valid after", 32'(out_valid0), 0);

      // all-zero vectors are dropped, then a single-bit vector
      in_valid = 1'b1;
      in_data  = 8'h00;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("zero out_valid", 32'(out_valid0), 0);
         chk("zero in_ready",  32'(in_ready0),  1);
      end
      in_data = 8'h80;
      tick();
      in_valid = 1'b0;
      in_data  = '0;
      chk("single out_valid", 32'(out_valid0), 1);
      chk("single out_idx",   32'(out_idx0),   7);
      chk("single out_last",  32'(out_last0),  1);
      chk("single out_count", 32'(out_count0), 1);
      tick();
      chk("single out_valid after", 32'(out_valid0), 0);

      // reset mid-burst
      in_valid = 1'b1;
      in_data  = 8'hF0;
      tick();
      in_valid = 1'b0;
      in_data  = '0;
      chk("midrst beat0 idx", 32'(out_idx0), 4);
      tick();
      chk("midrst beat1 idx", 32'(out_idx0), 5);
      tick();
      rst = 1'b1;
      #1;
      chk("midrst in_ready during rst", 32'(in_ready0), 0);
      tick();
      chk("midrst out_valid", 32'(out_valid0), 0);
      chk("midrst out_idx",   32'(out_idx0),   0);
      chk("midrst out_last",  32'(out_last0),  0);
      chk("midrst out_count", 32'(out_count0), 0);
      rst = 1'b0;
      #1;
      chk("midrst in_ready after", 32'(in_ready0), 1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("midrst no stale beat", 32'(out_valid0), 0);
      end

      // back-to-back vectors with in_valid held high
      in_valid = 1'b1;
      in_data  = 8'h01;
      tick();
      in_data = 8'h02;
      chk("b2b first valid",    32'(out_valid0), 1);
      chk("b2b first idx",      32'(out_idx0),   0);
      chk("b2b first last",     32'(out_last0),  1);
      chk("b2b in_ready busy",  32'(in_ready0),  0);
      tick();
      chk("b2b gap out_valid",  32'(out_valid0), 0);
      chk("b2b gap in_ready",   32'(in_ready0),  1);
      tick();
      in_valid = 1'b0;
      in_data  = '0;
      chk("b2b second valid",   32'(out_valid0), 1);
      chk("b2b second idx",     32'(out_idx0),   1);
      chk("b2b second last",    32'(out_last0),  1);
      chk("b2b second count",   32'(out_count0), 1);
      tick();
      chk("b2b end out_valid",  32'(out_valid0), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
